err_sq_meas_ctrl: RTL and testbench

- Measurement sequencer for the squared-error accumulator (err_sq_gen) in the MER measurement path.
- Clears the accumulator and gates its clk_en for exactly 2^WIN_LOG2 symbols.
- Drains the accumulator's 2-stage pipeline, then latches the window sum and offers it to software/readout over a valid/ready handshake.
- Supports one-shot and back-to-back (continuous) windows.

---
 rtl/err_sq_meas_ctrl_pkg.sv | 16 +
 rtl/err_sq_meas_ctrl_win.sv | 34 +++
 rtl/err_sq_meas_ctrl.sv | 107 ++++++++++
 tb/tb_err_sq_meas_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_sq_meas_ctrl_pkg.sv
// Shared constants and state encoding for the squared-error measurement sequencer.
package err_sq_meas_ctrl_pkg;

  localparam int LFSR_LEN      = 10;
  localparam int ERR_ACC_W     = 39;
  localparam int ERR_DRAIN_LEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_FILL    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } meas_state_e;

endpackage

// File: rtl/err_sq_meas_ctrl_win.sv
// Loadable up-counter with enable, synchronous clear and terminal-count flag;
// shared by the FILL and DRAIN phases of the measurement window.
module meas_win_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/err_sq_meas_ctrl.sv
// Sequencer that clears err_sq_gen, gates exactly 2^WIN_LOG2 symbols into it,
// flushes its pipeline and offers the latched window sum on valid/ready.
module err_sq_meas_ctrl
  import err_sq_meas_ctrl_pkg::*;
#(
  parameter int WIN_LOG2  = LFSR_LEN,
  parameter int ACC_W     = ERR_ACC_W,
  parameter int DRAIN_LEN = ERR_DRAIN_LEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic             acc_rst,
  output logic             acc_en,
  input  logic [ACC_W-1:0] acc_sq_err_in,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] FILL_TERM  = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [CNT_W-1:0] DRAIN_TERM = CNT_W'(DRAIN_LEN - 1);

  meas_state_e      state;
  logic             in_window;
  logic             abort_hit;
  logic             cnt_clr;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_term;

  assign in_window = (state == ST_FILL) || (state == ST_DRAIN);
  assign abort_hit = abort && (state != ST_IDLE);

  // The aborted cycle's symbol is blocked too, so nothing partial enters.
  assign acc_en  = clk_en && in_window && !abort;
  assign acc_rst = !reset_n || (state == ST_CLR);
  assign busy    = (state != ST_IDLE);

  assign cnt_term = (state == ST_DRAIN) ? DRAIN_TERM : FILL_TERM;
  assign cnt_clr  = (state == ST_CLR) || abort_hit || (acc_en && cnt_tc);

  meas_win_counter #(
    .WIDTH (CNT_W)
  ) u_win_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (acc_en),
    .term     (cnt_term),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // NOTE: this default consume is overridden by the CAPTURE assignment
      // below when both land on the same edge; the last <= in a block wins.
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      if (abort_hit) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state   <= ST_CLR;
              overrun <= 1'b0;
            end
          end
          ST_CLR: begin
            state <= ST_FILL;
          end
          ST_FILL: begin
            if (acc_en && cnt_tc) state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (acc_en && cnt_tc) state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            result       <= acc_sq_err_in;
            result_valid <= 1'b1;
            if (result_valid && !result_ready) overrun <= 1'b1;
            state <= continuous ? ST_CLR : ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_err_sq_meas_ctrl.sv
// Directed bench for err_sq_meas_ctrl with a behavioural err_sq_gen stand-in
// (sq_err -> acc -> out pipeline) feeding acc_sq_err_in.
module tb_err_sq_meas_ctrl;

  localparam int WL = 3;
  localparam int AW = 39;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic          result_ready = 1'b0;
  logic          acc_rst;
  logic          acc_en;
  logic          result_valid;
  logic          busy;
  logic          overrun;
  logic [AW-1:0] acc_sq_err_in;
  logic [AW-1:0] result;

  err_sq_meas_ctrl #(
    .WIN_LOG2  (WL),
    .ACC_W     (AW),
    .DRAIN_LEN (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clk_en        (clk_en),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .acc_rst       (acc_rst),
    .acc_en        (acc_en),
    .acc_sq_err_in (acc_sq_err_in),
    .result        (result),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Accumulator stand-in: ramp mode feeds 1,2,3,... per strobe, else cval.
  logic          ramp = 1'b0;
  logic [AW-1:0] cval = 39'h8000;
  logic [AW-1:0] m_sq, m_acc, m_out;
  int unsigned   m_idx;

  always @(posedge clk) begin
    if (acc_rst) begin
      m_sq  <= '0;
      m_acc <= '0;
      m_out <= '0;
      m_idx <= 0;
    end else if (acc_en) begin
      m_sq  <= ramp ? AW'(m_idx + 1) : cval;
      m_acc <= m_acc + m_sq;
      m_out <= m_acc;
      m_idx <= m_idx + 1;
    end
  end
  assign acc_sq_err_in = m_out;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe generator: clk_en high once every 'per' clocks, phase set by start_pulse.
  int per = 1;
  int base = 0;
  initial forever begin
    @(posedge clk);
    #2;
    clk_en = (((cyc - base) % per) == per - 1);
  end

  int en_total = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (acc_en) en_total++;
    if (acc_en && acc_rst) both_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;
  int s_edge = 0;
  int en_snap = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one tick after the edge that samples start (edge e0).
  task automatic start_pulse();
    step();
    start   = 1'b1;
    base    = cyc;
    en_snap = en_total;
    step();
    start  = 1'b0;
    s_edge = cyc;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = cyc - s_edge;
        break;
      end
    end
  endtask

  task automatic consume();
    step();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    @(negedge clk);
    check("consume_valid_drop", 64'(result_valid), 64'd0);
  endtask

  typedef struct {
    int            per;
    logic          ramp;
    logic [AW-1:0] exp_res;
    int            exp_lat;
    int            exp_en;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{per: 1, ramp: 1'b0, exp_res: 39'h40000, exp_lat: 12, exp_en: 10};
    vecs[1] = '{per: 3, ramp: 1'b0, exp_res: 39'h40000, exp_lat: 30, exp_en: 10};
    vecs[2] = '{per: 2, ramp: 1'b1, exp_res: 39'd36,    exp_lat: 22, exp_en: 10};
    vecs[3] = '{per: 1, ramp: 1'b1, exp_res: 39'd36,    exp_lat: 12, exp_en: 10};

    #1;
    check("rst_acc_rst", 64'(acc_rst), 64'd1);
    check("rst_acc_en", 64'(acc_en), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_acc_rst", 64'(acc_rst), 64'd0);

    // start together with abort from IDLE is ignored
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 4; v++) begin
      per  = vecs[v].per;
      ramp = vecs[v].ramp;
      cval = 39'h8000;
      start_pulse();
      @(negedge clk);
      check($sformatf("v%0d_clr_acc_rst", v), 64'(acc_rst), 64'd1);
      wait_valid(lat);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_result", v), 64'(result), 64'(vecs[v].exp_res));
      check($sformatf("v%0d_acc_en_count", v), 64'(en_total - en_snap), 64'(vecs[v].exp_en));
      check($sformatf("v%0d_busy_after", v), 64'(busy), 64'd0);
      check($sformatf("v%0d_overrun", v), 64'(overrun), 64'd0);
      consume();
    end

    // Continuous windows with consumer stalled -> overrun on second capture
    per  = 1;
    ramp = 1'b0;
    cval = 39'h8000;
    continuous = 1'b1;
    start_pulse();
    wait_valid(lat);
    check("cont_first_latency", 64'(lat), 64'd12);
    check("cont_first_result", 64'(result), 64'h40000);
    check("cont_first_busy", 64'(busy), 64'd1);
    cval = 39'h100;
    continuous = 1'b0;
    repeat (12) @(negedge clk);
    check("cont_second_result", 64'(result), 64'h800);
    check("cont_second_valid", 64'(result_valid), 64'd1);
    check("cont_overrun", 64'(overrun), 64'd1);
    check("cont_busy_end", 64'(busy), 64'd0);
    step();
    result_ready = 1'b1;
    @(negedge clk);
    check("ready_valid_same_clk", 64'(result_valid), 64'd1);
    step();
    result_ready = 1'b0;
    @(negedge clk);
    check("ready_valid_next_clk", 64'(result_valid), 64'd0);

    start_pulse();
    @(negedge clk);
    check("start_clears_overrun", 64'(overrun), 64'd0);
    check("start_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    check("post_overrun_latency", 64'(lat), 64'd12);
    check("post_overrun_result", 64'(result), 64'h800);

    // Abort on the 4th FILL symbol with a result still pending
    start_pulse();
    repeat (4) step();
    abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_acc_en", 64'(acc_en), 64'd0);
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_acc_en", 64'(acc_en), 64'd0);
    check("abort_symbols", 64'(en_total - en_snap), 64'd3);
    repeat (15) @(negedge clk);
    check("abort_valid_kept", 64'(result_valid), 64'd1);
    check("abort_result_kept", 64'(result), 64'h800);
    check("abort_overrun", 64'(overrun), 64'd0);

    // Async reset mid-DRAIN, away from a clock edge
    cval = 39'h20;
    start_pulse();
    repeat (10) step();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_acc_rst", 64'(acc_rst), 64'd1);
    check("async_acc_en", 64'(acc_en), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_valid", 64'(result_valid), 64'd0);
    check("async_result", 64'(result), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_acc_rst", 64'(acc_rst), 64'd0);
    start_pulse();
    wait_valid(lat);
    check("post_reset_latency", 64'(lat), 64'd12);
    check("post_reset_result", 64'(result), 64'h100);
    check("post_reset_acc_en_count", 64'(en_total - en_snap), 64'd10);

    // Consume on the CAPTURE edge plus a start pulse while busy
    cval = 39'h40;
    start_pulse();
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    result_ready = 1'b1;
    @(negedge clk);
    check("sim_pre_valid", 64'(result_valid), 64'd1);
    check("sim_pre_result", 64'(result), 64'h100);
    step();
    result_ready = 1'b0;
    @(negedge clk);
    check("sim_latency", 64'(cyc - s_edge), 64'd12);
    check("sim_valid", 64'(result_valid), 64'd1);
    check("sim_result", 64'(result), 64'h200);
    check("sim_overrun", 64'(overrun), 64'd0);
    check("sim_acc_en_count", 64'(en_total - en_snap), 64'd10);
    repeat (20) @(negedge clk);
    check("busy_start_ignored", 64'(busy), 64'd0);
    check("never_en_and_rst", 64'(both_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
